// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader harness stage.
// Used by prog_loader (optional watchdog: PROG_LOADER_WDOG_EN).
package prog_loader_pkg;

    localparam int unsigned IW_DEFAULT = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVF,
        ERR_WDOG
    } err_cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = &q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && !at_max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a machine-code stream into instruction memory, then runs the core and times it.
// Optional run watchdog enabled by defining PROG_LOADER_WDOG_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned D    = 12,
    parameter int unsigned IW   = IW_DEFAULT,
    parameter int unsigned CW   = 32,
    parameter int unsigned WDOG = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          reload,
    input  logic          req,
    output logic          im_wr_en,
    output logic [D-1:0]  im_wr_addr,
    output logic [IW-1:0] im_wr_data,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [D:0]    prog_len,
    output logic [CW-1:0] cycle_count
);

`ifdef PROG_LOADER_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif

    localparam logic [D:0]    PtrMax    = {1'b0, {D{1'b1}}};
    localparam logic [CW-1:0] WdogLimit = CW'(WDOG);

    state_t       state_q, state_d;
    err_cause_t   err_cause_q, err_cause_d;
    logic [D:0]   ptr_q, ptr_d;
    logic         ld_ready_q, ld_ready_d;
    logic         wr_en_q;
    logic [D-1:0] wr_addr_q;
    logic [IW-1:0] wr_data_q;

    logic beat;
    logic cnt_start;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_at_max;
    logic wdog_hit;

    assign beat     = ld_valid && ld_ready_q;
    assign wdog_hit = WdogOn && (cycle_count >= WdogLimit);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        err_cause_d = err_cause_q;
        cnt_start   = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                if (beat) begin
                    ptr_d = ptr_q + (D+1)'(1);
                    if (ld_last) begin
                        state_d = ARM;
                    end else if (ptr_q == PtrMax) begin
                        // Last address written without ld_last: memory is full.
                        state_d     = ERR;
                        err_cause_d = ERR_OVF;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            ARM: begin
                if (reload) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (req) begin
                    state_d   = RUN;
                    cnt_start = 1'b1;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d = DONE;
                end else if (wdog_hit) begin
                    state_d     = ERR;
                    err_cause_d = ERR_WDOG;
                end
            end
            DONE: begin
                if (reload) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (!req) begin
                    state_d = ARM;
                end
            end
            ERR: begin
                if (reload) begin
                    state_d     = IDLE;
                    ptr_d       = '0;
                    err_cause_d = ERR_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        ld_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            err_cause_q <= ERR_NONE;
            ptr_q       <= '0;
            ld_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            err_cause_q <= err_cause_d;
            ptr_q       <= ptr_d;
            ld_ready_q  <= ld_ready_d;
            wr_en_q     <= beat;
            if (beat) begin
                wr_addr_q <= ptr_q[D-1:0];
                wr_data_q <= ld_data;
            end
        end
    end

    // The core_done cycle is not counted, so the count reflects completed work cycles.
    assign cnt_clr = reset || cnt_start;
    assign cnt_en  = (state_q == RUN) && !core_done && !cnt_at_max;

    sat_counter #(
        .W (CW)
    ) u_cycle_cnt (
        .clk    (clk),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .q      (cycle_count),
        .at_max (cnt_at_max)
    );

    assign ld_ready   = ld_ready_q;
    assign im_wr_en   = wr_en_q;
    assign im_wr_addr = wr_addr_q;
    assign im_wr_data = wr_data_q;
    assign core_reset = (state_q != RUN);
    assign busy       = (state_q == LOAD) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign err        = (err_cause_q != ERR_NONE);
    assign prog_len   = ptr_q;

endmodule
